pulse_meter: RTL
================

// Module: pulse_meter
// PURPOSE
//   Receive side of the pulse/clock test harness. Samples an asynchronous pulse
//   train, synchronises it to clk and measures, per pulse, the high time and the
//   rising-to-rising period in clk cycles.
//   Each completed measurement is presented on a valid/ready result port for a
//   checker or logger.
// PARAMETERS
//   WIDTH        16  width of high_count / period_count (cycles)
//   SYNC_STAGES   2  synchroniser flops on signal, minimum 2
// PORTS
//   clk           in   1      single clock; all logic on posedge
//   reset         in   1      asynchronous, active-high; clears all state
//   signal        in   1      asynchronous pulse input to be measured
//   meas_ready    in   1      consumer accepts result when high at posedge clk
//   meas_valid    out  1      result registers hold an unconsumed measurement
//   high_count    out  WIDTH  cycles the synchronised signal was high in the pulse
//   period_count  out  WIDTH  cycles from that pulse's rising edge to the next rising edge
//   meas_sat      out  1      a counter saturated during this measurement
//   overrun       out  1      sticky: a measurement was dropped (result not consumed)
// BEHAVIOUR
// - Reset values: all outputs 0, FSM in IDLE, sync chain and s_prev 0, counters 0.
// - Synchronisation and edge detection
//   - s = last sync stage; s_prev = s delayed one cycle.
//   - rise = s & ~s_prev.
// - FSM, evaluated each posedge:
//   - IDLE: s==0 -> ARM. A signal already high at reset release is not measured.
//   - ARM: rise -> HIGH; hcnt=1, pcnt=1.
//   - HIGH: s==1 -> hcnt++, pcnt++. s==0 -> LOW, pcnt++.
//   - LOW: rise -> publish {hcnt,pcnt,sat}; restart hcnt=1, pcnt=1, sat=0; -> HIGH.
//     Otherwise pcnt++.
//   - Back-to-back: every rising edge after the first closes one measurement and
//     opens the next.
// - Arithmetic
//   - Counters saturate at 2^WIDTH-1; they never wrap.
//   - Any saturation sets the internal sat bit, which is reported as meas_sat.
//   - Counting continues at saturation until the next rise.
// - Latency: a publish loads the result registers and sets meas_valid on the same
//   posedge. This is SYNC_STAGES+1 posedges after the first posedge that samples
//   the new rising edge of signal high.
// - Handshake
//   - Transfer occurs at a posedge with meas_valid & meas_ready.
//   - While meas_valid=1, high_count, period_count and meas_sat are stable.
//   - meas_valid falls after a transfer unless a publish happens on the same edge.
// - Simultaneous events
//   - Publish with meas_valid=0: load the result, meas_valid=1.
//   - Publish with meas_valid & meas_ready: the old result transfers, the new one
//     loads, meas_valid stays 1.
//   - Publish with meas_valid & ~meas_ready: the new result is dropped, the old one
//     is kept, overrun=1.
// - overrun clears only on reset.
// - Reset asserted mid-measurement: immediate return to reset values.
//   - The partial measurement is discarded.
//   - After release, the FSM needs s==0 and then a rise before measuring again.
// TESTING
// - T1 (basic): reset 2 cycles, then signal 3 cycles high / 3 low, repeated.
//   -> first meas_valid 3 posedges after the 2nd rise is sampled;
//      high_count=3, period_count=6, meas_sat=0.
// - T2 (handshake): hold meas_ready=0 over 2 publishes.
//   -> the first result is held unchanged; overrun=1 after the 2nd publish.
//   - Then raise meas_ready for 1 cycle -> meas_valid=0 next cycle.
// - T3 (same-edge publish/accept): meas_ready=1 constant, pattern 1 high / 1 low.
//   -> meas_valid stays 1 continuously; each result high_count=1, period_count=2;
//      overrun=0.
// - T4 (saturation): WIDTH=4, signal 20 high / 2 low.
//   -> high_count=15, period_count=15, meas_sat=1.
//   - The next 3/3 pulse reports 3/6 with meas_sat=0.
// - T5 (reset mid-op): signal high at reset release, reset pulsed asynchronously
//   while in LOW.
//   -> all outputs 0 immediately; no result until a full low->high->low->high
//      sequence is seen.
// - T6 (async input): signal edges offset from clk by random fractions of a cycle.
//   -> period_count within ±1 of the nominal value; high_count + low time
//      = period_count.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: receive side of the pulse/clock test harness.
// Synchronises an asynchronous pulse train to clk and measures, per pulse, the
// high time and the rising-to-rising period in clk cycles. Each completed
// measurement is offered on a valid/ready result port; a result that cannot be
// delivered because the previous one is still pending is dropped and flagged
// by the sticky overrun bit.
module pulse_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [WIDTH-1:0] high_count,
    output logic [WIDTH-1:0] period_count,
    output logic             meas_sat,
    output logic             overrun
);

    // A synchroniser shorter than two flops is not safe, so clamp it.
    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    // Synchroniser and edge-detect pipeline
    logic [NSYNC-1:0] sync_r;
    logic             s_prev_r;
    logic             rise_r;
    // primed_r[i] is set once pipeline stage i holds a sample taken after reset
    logic [NSYNC:0]   primed_r;

    // Measurement state
    state_t           state_r;
    logic [WIDTH-1:0] hcnt_r;
    logic [WIDTH-1:0] pcnt_r;
    logic             sat_r;

    logic             s_s;
    logic             level_ok_s;
    logic             publish_s;
    logic [WIDTH:0]   hinc_s;
    logic [WIDTH:0]   pinc_s;

    // Saturating increment: returns {saturated, next_value}. A counter already
    // at its maximum stays there and reports saturation instead of wrapping.
    function automatic logic [WIDTH:0] sat_inc(input logic [WIDTH-1:0] value);
        logic [WIDTH:0] result;
        if (value == CNT_MAX) begin
            result = {1'b1, CNT_MAX};
        end else begin
            result = {1'b0, value + CNT_ONE};
        end
        return result;
    endfunction

    // Decode pipeline taps, the publish condition and the counter increments.
    always_comb begin
        s_s        = sync_r[NSYNC-1];
        // s_prev_r is the level the FSM acts on; it is aligned with rise_r.
        level_ok_s = primed_r[NSYNC];
        publish_s  = (state_r == ST_LOW) && rise_r;
        hinc_s     = sat_inc(hcnt_r);
        pinc_s     = sat_inc(pcnt_r);
    end

    // Synchronise the input, register the rising edge and track pipeline fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r   <= {NSYNC{1'b0}};
            s_prev_r <= 1'b0;
            rise_r   <= 1'b0;
            primed_r <= {(NSYNC + 1){1'b0}};
        end else begin
            sync_r   <= {sync_r[NSYNC-2:0], signal};
            s_prev_r <= s_s;
            rise_r   <= s_s & ~s_prev_r;
            primed_r <= {primed_r[NSYNC-1:0], 1'b1};
        end
    end

    // Measurement FSM: arm on a genuine low level, then count high time and
    // period between consecutive rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            hcnt_r  <= CNT_ZERO;
            pcnt_r  <= CNT_ZERO;
            sat_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Zeros left in the pipeline by reset do not count as low.
                    if (level_ok_s && !s_prev_r) begin
                        state_r <= ST_ARM;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (rise_r) begin
                        state_r <= ST_HIGH;
                        hcnt_r  <= CNT_ONE;
                        pcnt_r  <= CNT_ONE;
                        sat_r   <= 1'b0;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_HIGH: begin
                    if (s_prev_r) begin
                        hcnt_r <= hinc_s[WIDTH-1:0];
                        pcnt_r <= pinc_s[WIDTH-1:0];
                        sat_r  <= sat_r | hinc_s[WIDTH] | pinc_s[WIDTH];
                    end else begin
                        state_r <= ST_LOW;
                        pcnt_r  <= pinc_s[WIDTH-1:0];
                        sat_r   <= sat_r | pinc_s[WIDTH];
                    end
                end
                ST_LOW: begin
                    if (rise_r) begin
                        // This edge closes the current pulse and opens the next.
                        state_r <= ST_HIGH;
                        hcnt_r  <= CNT_ONE;
                        pcnt_r  <= CNT_ONE;
                        sat_r   <= 1'b0;
                    end else begin
                        pcnt_r <= pinc_s[WIDTH-1:0];
                        sat_r  <= sat_r | pinc_s[WIDTH];
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    hcnt_r  <= CNT_ZERO;
                    pcnt_r  <= CNT_ZERO;
                    sat_r   <= 1'b0;
                end
            endcase
        end
    end

    // Result port: load on publish when the slot is free or being emptied,
    // otherwise drop the new result and flag overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_valid   <= 1'b0;
            high_count   <= CNT_ZERO;
            period_count <= CNT_ZERO;
            meas_sat     <= 1'b0;
            overrun      <= 1'b0;
        end else if (publish_s) begin
            if (!meas_valid || meas_ready) begin
                meas_valid   <= 1'b1;
                high_count   <= hcnt_r;
                period_count <= pcnt_r;
                meas_sat     <= sat_r;
            end else begin
                overrun <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= meas_valid;
        end
    end

endmodule
